// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: issues in-order imem requests, pairs responses with PCs, buffers for decode.
// Optional macro IFQ_BYPASS_EN enables a same-cycle response bypass to decode when the queue is empty.
module if_id_queue #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [SIZE-1:0] imem_rdata,
  input  logic            flush,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [SIZE-1:0] dec_pc,
  output logic [SIZE-1:0] dec_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [SIZE-1:0] NOP = SIZE'(32'h0000_0013);

  logic [SIZE-1:0] r_os_pc    [DEPTH];
  logic [SIZE-1:0] r_out_pc   [DEPTH];
  logic [SIZE-1:0] r_out_instr[DEPTH];
  logic [CW-1:0]   r_os_wr, r_os_rd;
  logic [CW-1:0]   r_out_wr, r_out_rd;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_os_cnt, w_out_cnt;
  logic [SW-1:0]   w_credit_sum;
  logic            w_credit_ok;
  logic            w_out_empty;
  logic            w_rsp_drop, w_rsp_take;
  logic            w_byp_vld;
  logic            w_dec_pop;
  logic            w_os_push, w_os_pop;
  logic            w_out_push, w_out_pop;
  logic [SIZE-1:0] w_os_head;

  assign w_os_cnt     = r_os_wr - r_os_rd;
  assign w_out_cnt    = r_out_wr - r_out_rd;
  // Every granted request reserves a slot until decode drains it or its dropped response returns.
  assign w_credit_sum = SW'(w_os_cnt) + SW'(w_out_cnt) + SW'(r_drop_cnt);
  assign w_credit_ok  = w_credit_sum < SW'(DEPTH);
  assign w_out_empty  = (w_out_cnt == '0);
  assign w_os_head    = r_os_pc[r_os_rd[PW-1:0]];

  assign imem_req  = reset & pc_valid & w_credit_ok & ~flush;
  assign imem_addr = pc_in;
  assign pc_ready  = imem_req & imem_gnt;

  assign w_rsp_drop = imem_rvalid & (r_drop_cnt != '0);
  assign w_rsp_take = reset & imem_rvalid & ~flush & (r_drop_cnt == '0);

`ifdef IFQ_BYPASS_EN
  assign w_byp_vld = w_out_empty & w_rsp_take;
`else
  assign w_byp_vld = 1'b0;
`endif

  assign dec_valid = reset & (~w_out_empty | w_byp_vld);

  always_comb begin
    dec_pc    = '0;
    dec_instr = NOP;
    if (!w_out_empty) begin
      dec_pc    = r_out_pc[r_out_rd[PW-1:0]];
      dec_instr = r_out_instr[r_out_rd[PW-1:0]];
    end else if (w_byp_vld) begin
      dec_pc    = w_os_head;
      dec_instr = imem_rdata;
    end
  end

  assign w_dec_pop  = dec_valid & dec_ready & ~flush;
  assign w_os_push  = pc_ready;
  assign w_os_pop   = w_rsp_take;
  // A bypassed word consumed by decode never enters the output FIFO.
  assign w_out_push = w_rsp_take & ~(w_byp_vld & dec_ready);
  assign w_out_pop  = w_dec_pop & ~w_out_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_os_wr    <= '0;
      r_os_rd    <= '0;
      r_out_wr   <= '0;
      r_out_rd   <= '0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_os_wr    <= '0;
      r_os_rd    <= '0;
      r_out_wr   <= '0;
      r_out_rd   <= '0;
      r_drop_cnt <= r_drop_cnt + w_os_cnt - CW'(imem_rvalid);
    end else begin
      if (w_os_push)  r_os_wr    <= r_os_wr + CW'(1);
      if (w_os_pop)   r_os_rd    <= r_os_rd + CW'(1);
      if (w_out_push) r_out_wr   <= r_out_wr + CW'(1);
      if (w_out_pop)  r_out_rd   <= r_out_rd + CW'(1);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  // Storage arrays need no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_os_push) r_os_pc[r_os_wr[PW-1:0]] <= pc_in;
    if (w_out_push) begin
      r_out_pc[r_out_wr[PW-1:0]]    <= w_os_head;
      r_out_instr[r_out_wr[PW-1:0]] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: table-driven per-cycle vectors plus hand-written flush/reset/bypass sequences.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, reset;
  logic [31:0] pc_in, imem_addr, imem_rdata, dec_pc, dec_instr;
  logic        pc_valid, pc_ready, imem_req, imem_gnt, imem_rvalid;
  logic        flush, dec_valid, dec_ready;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_queue #(.SIZE(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        flush;
    logic        dec_ready;
    logic        e_pc_ready;
    logic        e_req;
    logic        e_dec_valid;
    logic [31:0] e_dec_pc;
    logic [31:0] e_dec_instr;
  } vec_t;

  function automatic vec_t v(logic pv, logic [31:0] pc, logic g, logic rv, logic [31:0] rd,
                             logic fl, logic rdy, logic epr, logic ereq, logic edv,
                             logic [31:0] epc, logic [31:0] ein);
    vec_t x;
    x.pc_valid = pv; x.pc_in = pc; x.gnt = g; x.rvalid = rv; x.rdata = rd;
    x.flush = fl; x.dec_ready = rdy; x.e_pc_ready = epr; x.e_req = ereq;
    x.e_dec_valid = edv; x.e_dec_pc = epc; x.e_dec_instr = ein;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic g, input logic rv,
                       input logic [31:0] rd, input logic fl, input logic rdy);
    pc_valid = pv; pc_in = pc; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    flush = fl; dec_ready = rdy;
  endtask

  // Drive at negedge, sample 1ns later, then let the next rising edge commit.
  task automatic apply(input vec_t x, input string name, input int idx);
    drive(x.pc_valid, x.pc_in, x.gnt, x.rvalid, x.rdata, x.flush, x.dec_ready);
    #1;
    chk({name, ".pc_ready"},  idx, 32'(pc_ready),  32'(x.e_pc_ready));
    chk({name, ".imem_req"},  idx, 32'(imem_req),  32'(x.e_req));
    chk({name, ".dec_valid"}, idx, 32'(dec_valid), 32'(x.e_dec_valid));
    chk({name, ".dec_pc"},    idx, dec_pc,    x.e_dec_pc);
    chk({name, ".dec_instr"}, idx, dec_instr, x.e_dec_instr);
    @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst.dec_valid", 0, 32'(dec_valid), 32'd0);
    chk("rst.dec_pc",    0, dec_pc, 32'd0);
    chk("rst.dec_instr", 0, dec_instr, NOP);
    chk("rst.pc_ready",  0, 32'(pc_ready), 32'd0);
    chk("rst.imem_req",  0, 32'(imem_req), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef IFQ_BYPASS_EN
    seq.delete();
    seq.push_back(v(1, 32'h20, 1, 0, 0,            0, 1, 1, 1, 0, 32'h0,  NOP));
    seq.push_back(v(0, 32'h0,  0, 1, 32'h00A00093, 0, 1, 0, 0, 1, 32'h20, 32'h00A00093));
    seq.push_back(v(0, 32'h0,  0, 0, 0,            0, 1, 0, 0, 0, 32'h0,  NOP));
    foreach (seq[i]) apply(seq[i], "bypass", i);
`else
    // Stream: 2-cycle response latency, decode always ready.
    tbl.push_back(v(1, 32'h0, 1, 0, 0,            0, 1, 1, 1, 0, 32'h0, NOP));
    tbl.push_back(v(1, 32'h4, 1, 0, 0,            0, 1, 1, 1, 0, 32'h0, NOP));
    tbl.push_back(v(1, 32'h8, 1, 1, 32'h11100093, 0, 1, 1, 1, 0, 32'h0, NOP));
    tbl.push_back(v(1, 32'hC, 1, 1, 32'h22200093, 0, 1, 1, 1, 1, 32'h0, 32'h11100093));
    tbl.push_back(v(0, 32'h0, 1, 1, 32'h33300093, 0, 1, 0, 0, 1, 32'h4, 32'h22200093));
    tbl.push_back(v(0, 32'h0, 1, 1, 32'h44400093, 0, 1, 0, 0, 1, 32'h8, 32'h33300093));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,            0, 1, 0, 0, 1, 32'hC, 32'h44400093));
    tbl.push_back(v(0, 32'h0, 0, 0, 0,            0, 1, 0, 0, 0, 32'h0, NOP));
    // Backpressure: credit exhausts at DEPTH, one pop frees exactly one grant.
    tbl.push_back(v(1, 32'h10, 1, 0, 0,     0, 0, 1, 1, 0, 32'h0,  NOP));
    tbl.push_back(v(1, 32'h14, 1, 1, 32'hA0, 0, 0, 1, 1, 0, 32'h0,  NOP));
    tbl.push_back(v(1, 32'h18, 1, 1, 32'hA1, 0, 0, 1, 1, 1, 32'h10, 32'hA0));
    tbl.push_back(v(1, 32'h1C, 1, 1, 32'hA2, 0, 0, 1, 1, 1, 32'h10, 32'hA0));
    tbl.push_back(v(1, 32'h20, 1, 1, 32'hA3, 0, 0, 0, 0, 1, 32'h10, 32'hA0));
    tbl.push_back(v(1, 32'h20, 1, 0, 0,     0, 0, 0, 0, 1, 32'h10, 32'hA0));
    tbl.push_back(v(1, 32'h20, 1, 0, 0,     0, 1, 0, 0, 1, 32'h10, 32'hA0));
    tbl.push_back(v(1, 32'h20, 1, 0, 0,     0, 0, 1, 1, 1, 32'h14, 32'hA1));
    tbl.push_back(v(1, 32'h24, 1, 0, 0,     0, 0, 0, 0, 1, 32'h14, 32'hA1));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'hA4, 0, 1, 0, 0, 1, 32'h14, 32'hA1));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,     0, 1, 0, 0, 1, 32'h18, 32'hA2));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,     0, 1, 0, 0, 1, 32'h1C, 32'hA3));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,     0, 1, 0, 0, 1, 32'h20, 32'hA4));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,     0, 1, 0, 0, 0, 32'h0,  NOP));
    // Grant withheld: request stays up, nothing accepted until gnt.
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1, 32'h30, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, NOP));
    tbl.push_back(v(1, 32'h30, 1, 0, 0,      0, 0, 1, 1, 0, 32'h0,  NOP));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,      0, 0, 0, 0, 0, 32'h0,  NOP));
    tbl.push_back(v(0, 32'h0,  0, 1, 32'hB0, 0, 0, 0, 0, 0, 32'h0,  NOP));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,      0, 1, 0, 0, 1, 32'h30, 32'hB0));
    tbl.push_back(v(0, 32'h0,  0, 0, 0,      0, 0, 0, 0, 0, 32'h0,  NOP));
    foreach (tbl[i]) apply(tbl[i], "tbl", i);

    // Flush with 3 in flight and a response in the flush cycle: all three words dropped.
    seq.delete();
    seq.push_back(v(1, 32'h40,  1, 0, 0,            0, 0, 1, 1, 0, 32'h0,   NOP));
    seq.push_back(v(1, 32'h44,  1, 0, 0,            0, 0, 1, 1, 0, 32'h0,   NOP));
    seq.push_back(v(1, 32'h48,  1, 0, 0,            0, 0, 1, 1, 0, 32'h0,   NOP));
    seq.push_back(v(1, 32'h4C,  1, 1, 32'hBAD0,     1, 0, 0, 0, 0, 32'h0,   NOP));
    seq.push_back(v(1, 32'h100, 1, 1, 32'hBAD1,     0, 0, 1, 1, 0, 32'h0,   NOP));
    seq.push_back(v(0, 32'h0,   0, 1, 32'hBAD2,     0, 0, 0, 0, 0, 32'h0,   NOP));
    seq.push_back(v(0, 32'h0,   0, 1, 32'hDEAD0013, 0, 0, 0, 0, 0, 32'h0,   NOP));
    seq.push_back(v(0, 32'h0,   0, 0, 0,            0, 1, 0, 0, 1, 32'h100, 32'hDEAD0013));
    seq.push_back(v(0, 32'h0,   0, 0, 0,            0, 1, 0, 0, 0, 32'h0,   NOP));
    foreach (seq[i]) apply(seq[i], "flush", i);

    // Reset mid-cycle with 3 entries buffered, then restart from PC 0.
    seq.delete();
    seq.push_back(v(1, 32'h50, 1, 0, 0,     0, 0, 1, 1, 0, 32'h0,  NOP));
    seq.push_back(v(1, 32'h54, 1, 1, 32'hC0, 0, 0, 1, 1, 0, 32'h0,  NOP));
    seq.push_back(v(1, 32'h58, 1, 1, 32'hC1, 0, 0, 1, 1, 1, 32'h50, 32'hC0));
    seq.push_back(v(0, 32'h0,  0, 1, 32'hC2, 0, 0, 0, 0, 1, 32'h50, 32'hC0));
    foreach (seq[i]) apply(seq[i], "prerst", i);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("midrst.pre_dec_valid", 0, 32'(dec_valid), 32'd1);
    chk("midrst.pre_dec_pc",    0, dec_pc, 32'h50);
    #1 reset = 1'b0;
    #1;
    chk("midrst.dec_valid", 0, 32'(dec_valid), 32'd0);
    chk("midrst.dec_pc",    0, dec_pc, 32'd0);
    chk("midrst.dec_instr", 0, dec_instr, NOP);
    chk("midrst.pc_ready",  0, 32'(pc_ready), 32'd0);
    chk("midrst.imem_req",  0, 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seq.delete();
    seq.push_back(v(1, 32'h0, 1, 0, 0,          0, 0, 1, 1, 0, 32'h0, NOP));
    seq.push_back(v(0, 32'h0, 0, 1, 32'h1234,   0, 0, 0, 0, 0, 32'h0, NOP));
    seq.push_back(v(0, 32'h0, 0, 0, 0,          0, 1, 0, 0, 1, 32'h0, 32'h1234));
    seq.push_back(v(0, 32'h0, 0, 0, 0,          0, 1, 0, 0, 0, 32'h0, NOP));
    foreach (seq[i]) apply(seq[i], "postrst", i);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
